// File: rtl/exec_sequencer_if.sv
// Instruction-memory fetch channel between the sequencer (master) and the memory (slave).
interface exec_sequencer_if #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute sequencer: owns pc, the instruction register and the retired count,
// and gates the decoder's write strobes to the single EXECUTE cycle.
module exec_sequencer #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16,
  parameter int CntWidth          = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         halt_req,
  exec_sequencer_if.master             imem,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  input  logic                         dec_wr_en,
  input  logic                         dec_stat_wr_en,
  input  logic                         dec_cnt_wr_en,
  input  logic                         dec_add_offset,
  input  logic [PC_WIDTH-1:0]          dec_literal_adr,
  output logic                         reg_wr_en,
  output logic                         stat_wr_en,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         busy,
  output logic [CntWidth-1:0]          retired_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXECUTE} state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic                go;

  assign go             = run & ~halt_req;
  assign busy           = (state != IDLE);
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    reg_wr_en  = 1'b0;
    stat_wr_en = 1'b0;
    case (state)
      IDLE:    if (go) state_nxt = FETCH;
      FETCH:   if (imem.imem_ack) state_nxt = DECODE;
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: begin
        reg_wr_en  = dec_wr_en;
        stat_wr_en = dec_stat_wr_en;
        state_nxt  = go ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // add_offset without cnt_wr_en is deliberately a plain increment
  always_comb begin
    pc_nxt = pc + PC_WIDTH'(1);
    if (dec_cnt_wr_en)
      pc_nxt = dec_add_offset ? pc + dec_literal_adr : dec_literal_adr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      instruction <= '0;
      retired_cnt <= '0;
    end else begin
      if (state == FETCH && imem.imem_ack) instruction <= imem.imem_data;
      if (state == EXECUTE) begin
        pc <= pc_nxt;
        if (retired_cnt != {CntWidth{1'b1}}) retired_cnt <= retired_cnt + CntWidth'(1);
      end
    end
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 8, meaning program counter and instruction memory address width.
REQ-002 The block SHALL have parameter PROGRAM_DataWidth, default 16, meaning instruction word width.
REQ-003 The block SHALL have parameter CntWidth, default 16, meaning retired-instruction counter width.
REQ-004 Port clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port run  in  1  level: permit instruction execution.
REQ-007 Port halt_req  in  1  level: stop after the current instruction.
REQ-008 Port imem_req  out  1  instruction fetch request.
REQ-009 Port imem_addr  out  PC_WIDTH  fetch address; equals pc.
REQ-010 Port imem_ack  in  1  fetch data valid this cycle.
REQ-011 Port imem_data  in  PROGRAM_DataWidth  fetched instruction word.
REQ-012 Port instruction  out  PROGRAM_DataWidth  instruction register; feeds the decoder.
REQ-013 Port dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en, dec_add_offset  in  1 each  decoder controls.
REQ-014 Port dec_literal_adr  in  PC_WIDTH  decoder jump target or offset.
REQ-015 Port reg_wr_en  out  1  gated register-file write strobe.
REQ-016 Port stat_wr_en  out  1  gated status-register write strobe.
REQ-017 Port pc  out  PC_WIDTH  program counter.
REQ-018 Port busy  out  1  high in any state except IDLE.
REQ-019 Port retired_cnt  out  CntWidth  count of executed instructions.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, DECODE and EXECUTE, exactly one active per cycle.
REQ-021 IDLE: moves to FETCH when run=1 and halt_req=0; otherwise stays.
REQ-022 FETCH: imem_req=1; stays while imem_ack=0 with no timeout; on imem_ack=1 latches imem_data into instruction and moves to DECODE.
REQ-023 DECODE: one cycle for decoder settle; all strobes 0; moves to EXECUTE.
REQ-024 EXECUTE: one cycle; reg_wr_en=dec_wr_en, stat_wr_en=dec_stat_wr_en; reg_wr_en and stat_wr_en SHALL be 0 in every other state.
REQ-025 PC update, on EXECUTE exit only: dec_cnt_wr_en=1 and dec_add_offset=1 -> pc+dec_literal_adr; dec_cnt_wr_en=1 and dec_add_offset=0 -> dec_literal_adr; otherwise pc+1.
REQ-026 All PC arithmetic SHALL be modulo 2^PC_WIDTH (0xFF+1 -> 0x00; the offset is effectively two's complement).
REQ-027 dec_add_offset=1 with dec_cnt_wr_en=0 SHALL be treated as a sequential pc+1.
REQ-028 EXECUTE exit: to FETCH if run=1 and halt_req=0, else to IDLE.
REQ-029 halt_req or run=0 during FETCH or DECODE SHALL NOT abort; the instruction completes, and no partial writes occur.
REQ-030 retired_cnt SHALL increment by 1 on each EXECUTE cycle and saturate at all-ones.
REQ-031 Minimum latency per instruction, zero-wait memory (ack in the first FETCH cycle): 3 cycles; each wait cycle adds 1.
REQ-032 imem_data SHALL be ignored outside FETCH, and imem_ack SHALL be ignored outside FETCH.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=IDLE, pc=0, instruction=0, retired_cnt=0, imem_req=0, reg_wr_en=0, stat_wr_en=0, busy=0.
REQ-034 Reset during any state, including EXECUTE, SHALL suppress that cycle's strobes and PC update.
REQ-035 Reset deassertion SHALL take effect at the first rising clk edge with rst_n=1; the next state is decided by REQ-021.

Verification
REQ-036 Reset with run=1, then release -> pc=0x00, busy=0 until the first edge after release, then FETCH with imem_req=1 and imem_addr=0x00.
REQ-037 Sequential ALU instruction with dec_wr_en=1 and imem_ack delayed 3 cycles -> instruction latched on the ack edge; reg_wr_en high exactly 1 cycle, 2 cycles after the ack; pc 0x00 -> 0x01; retired_cnt=1.
REQ-038 GOTO: dec_cnt_wr_en=1, dec_add_offset=0, literal 0x3F at pc=0x05 -> pc=0x3F, reg_wr_en=0 and stat_wr_en=0 throughout.
REQ-039 Relative jump: dec_cnt_wr_en=1, dec_add_offset=1, pc=0xFE, literal 0x05 -> pc=0x03; literal 0xFE at pc=0x10 -> pc=0x0E.
REQ-040 halt_req asserted during FETCH wait -> the instruction completes, pc advances, then IDLE with busy=0 and imem_req=0; run=1 with halt_req=0 resumes the fetch at the new pc.
REQ-041 rst_n pulsed low during EXECUTE with dec_wr_en=1 -> no reg_wr_en pulse; pc=0 and retired_cnt=0 immediately.
